fractal_engine: RTL and testbench

// Parametrised next-generation escape-time engine. Accepts one pixel per handshake and maps it to a complex point
// (pixel * zoom-dependent step + offset). Iterates z <- z^2 + c in Mandelbrot or Julia mode and returns the iteration count.

---
 rtl/fractal_engine.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_fractal_engine.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fractal_engine.sv
// -----------------------------------------------------------------------------
// fractal_engine
//
// Escape-time engine for Mandelbrot and Julia sets. A pixel request is accepted
// on a valid/ready handshake, mapped to a complex point, and iterated with
// z <- z^2 + c at one iteration per clock. The result is offered on a
// valid/ready output and held stable until the consumer takes it.
//
// The mapped point is p = offset + pixel * 2^-(STEP_BASE_SHIFT + zoom) on each
// axis. In Mandelbrot mode c = p and z0 = 0. In Julia mode c = julia_c and
// z0 = p.
//
// Fixed point: all complex values are signed Q(W-F).F words. Squares and
// cross products are rescaled by >>> F and saturated to W bits. Additions
// wrap modulo 2^W.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   in_valid / in_ready        pixel request handshake
//   pixel_x, pixel_y           unsigned pixel coordinates
//   zoom                       step = 2^-(STEP_BASE_SHIFT + zoom)
//   x_offset, y_offset         signed offsets of the view
//   mode                       0 = Mandelbrot, 1 = Julia
//   julia_cr, julia_ci         Julia constant
//   iterations_max             iteration cap
//   out_valid / out_ready      result handshake, with full backpressure
//   out_pixel_x, out_pixel_y   echoed pixel coordinates
//   out_cr, out_ci             mapped complex point of the pixel
//   out_iterations             iterations completed
//   out_escaped                1 = escaped, 0 = stopped at iterations_max
//   busy                       engine is not idle
// -----------------------------------------------------------------------------
module fractal_engine #(
   parameter int PIXEL_DATA_WIDTH   = 10,
   parameter int ENGINE_DATA_WIDTH  = 25,
   parameter int ENGINE_FRACT_WIDTH = 20,
   parameter int ITERATIONS_WIDTH   = 9,
   parameter int STEP_BASE_SHIFT    = 8,
   parameter int ESCAPE_INT         = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [PIXEL_DATA_WIDTH-1:0]         pixel_x,
   input  logic [PIXEL_DATA_WIDTH-1:0]         pixel_y,
   input  logic [2:0]                          zoom,
   input  logic signed [ENGINE_DATA_WIDTH-1:0] x_offset,
   input  logic signed [ENGINE_DATA_WIDTH-1:0] y_offset,
   input  logic                                mode,
   input  logic signed [ENGINE_DATA_WIDTH-1:0] julia_cr,
   input  logic signed [ENGINE_DATA_WIDTH-1:0] julia_ci,
   input  logic [ITERATIONS_WIDTH-1:0]         iterations_max,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [PIXEL_DATA_WIDTH-1:0]         out_pixel_x,
   output logic [PIXEL_DATA_WIDTH-1:0]         out_pixel_y,
   output logic signed [ENGINE_DATA_WIDTH-1:0] out_cr,
   output logic signed [ENGINE_DATA_WIDTH-1:0] out_ci,
   output logic [ITERATIONS_WIDTH-1:0]         out_iterations,
   output logic                                out_escaped,
   output logic                                busy
);

   localparam int W  = ENGINE_DATA_WIDTH;
   localparam int F  = ENGINE_FRACT_WIDTH;
   localparam int PW = PIXEL_DATA_WIDTH;
   localparam int IW = ITERATIONS_WIDTH;

   // Pixel shift at zoom 0; each zoom step halves the pixel pitch.
   localparam int BASE_SHIFT = F - STEP_BASE_SHIFT;

   // Saturation limits expressed in the double-width product domain.
   localparam logic signed [2*W-1:0] SAT_HI = {{(W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W-1:0] SAT_LO = {{(W+1){1'b1}}, {(W-1){1'b0}}};

   // Escape threshold on |z|^2, in the W+1 bit sum domain.
   localparam logic signed [W:0] ESC_LIMIT = (W+1)'(ESCAPE_INT) << F;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAP  = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t state;

   // ---------------------------------------------------------------------------
   // Request configuration, captured only at acceptance
   // ---------------------------------------------------------------------------
   logic [PW-1:0]       px_q;
   logic [PW-1:0]       py_q;
   logic [2:0]          zoom_q;
   logic signed [W-1:0] x_off_q;
   logic signed [W-1:0] y_off_q;
   logic                mode_q;
   logic signed [W-1:0] julia_cr_q;
   logic signed [W-1:0] julia_ci_q;
   logic [IW-1:0]       max_q;

   // ---------------------------------------------------------------------------
   // Iteration state
   // ---------------------------------------------------------------------------
   logic signed [W-1:0] p_r;
   logic signed [W-1:0] p_i;
   logic signed [W-1:0] cr;
   logic signed [W-1:0] ci;
   logic signed [W-1:0] zr;
   logic signed [W-1:0] zi;
   logic [IW-1:0]       iter;

   // ---------------------------------------------------------------------------
   // Pixel to complex-plane mapping
   // ---------------------------------------------------------------------------
   logic [7:0]          map_shift;
   logic signed [W-1:0] map_r;
   logic signed [W-1:0] map_i;

   assign map_shift = 8'(BASE_SHIFT) - 8'(zoom_q);

   // The pixel is zero-extended before shifting. The sum wraps modulo 2^W.
   assign map_r = x_off_q + (W'(px_q) << map_shift);
   assign map_i = y_off_q + (W'(py_q) << map_shift);

   // ---------------------------------------------------------------------------
   // One iteration of z^2 + c
   // ---------------------------------------------------------------------------
   // Rescales a full-precision product back to Q(W-F).F and clamps the result
   // to the W-bit signed range. This keeps a diverging orbit from wrapping
   // back to a small magnitude and looking bounded.
   function automatic logic signed [W-1:0] sat_scale(input logic signed [2*W-1:0] prod);
      logic signed [2*W-1:0] scaled;
      scaled = prod >>> F;
      if (scaled > SAT_HI)
         return SAT_HI[W-1:0];
      else if (scaled < SAT_LO)
         return SAT_LO[W-1:0];
      else
         return scaled[W-1:0];
   endfunction

   logic signed [2*W-1:0] prod_rr;
   logic signed [2*W-1:0] prod_ii;
   logic signed [2*W-1:0] prod_ri;
   logic signed [W-1:0]   zr_sq;
   logic signed [W-1:0]   zi_sq;
   logic signed [W-1:0]   zr_zi;
   logic signed [W:0]     mag_sq;
   logic                  escape;
   logic                  at_cap;
   logic signed [W-1:0]   zr_next;
   logic signed [W-1:0]   zi_next;

   // Operands are sign-extended to the product width before multiplying.
   assign prod_rr = (2*W)'(zr) * (2*W)'(zr);
   assign prod_ii = (2*W)'(zi) * (2*W)'(zi);
   assign prod_ri = (2*W)'(zr) * (2*W)'(zi);

   assign zr_sq = sat_scale(prod_rr);
   assign zi_sq = sat_scale(prod_ii);
   assign zr_zi = sat_scale(prod_ri);

   // Both squares may saturate at the same time, so the magnitude needs one
   // extra bit to avoid wrapping.
   assign mag_sq = (W+1)'(zr_sq) + (W+1)'(zi_sq);
   assign escape = mag_sq > ESC_LIMIT;
   assign at_cap = iter == max_q;

   // Real and imaginary parts of z^2 + c, wrapping modulo 2^W.
   assign zr_next = zr_sq - zi_sq + cr;
   assign zi_next = (zr_zi <<< 1) + ci;

   // ---------------------------------------------------------------------------
   // Control FSM and result registers
   // ---------------------------------------------------------------------------
   // NOTE: every register in a clocked block is assigned with <=, so that all
   // of them update from the values present before the edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         in_ready       <= 1'b1;
         out_valid      <= 1'b0;
         busy           <= 1'b0;
         out_pixel_x    <= '0;
         out_pixel_y    <= '0;
         out_cr         <= '0;
         out_ci         <= '0;
         out_iterations <= '0;
         out_escaped    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  state    <= MAP;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
               end
            end

            MAP: begin
               state <= ITER;
            end

            ITER: begin
               // Escape is tested before the cap. A point that escapes on the
               // capped iteration is therefore reported as escaped.
               if (escape || at_cap) begin
                  state          <= DONE;
                  out_valid      <= 1'b1;
                  out_escaped    <= escape;
                  out_iterations <= iter;
                  out_pixel_x    <= px_q;
                  out_pixel_y    <= py_q;
                  out_cr         <= p_r;
                  out_ci         <= p_i;
               end
            end

            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Datapath registers
   // ---------------------------------------------------------------------------
   // NOTE: these registers have no reset. Each one is written before it is
   // read in every pass through the FSM. Leaving out the reset also keeps it
   // off the wide datapath.
   always_ff @(posedge clk) begin
      case (state)
         IDLE: begin
            if (in_valid) begin
               px_q       <= pixel_x;
               py_q       <= pixel_y;
               zoom_q     <= zoom;
               x_off_q    <= x_offset;
               y_off_q    <= y_offset;
               mode_q     <= mode;
               julia_cr_q <= julia_cr;
               julia_ci_q <= julia_ci;
               max_q      <= iterations_max;
            end
         end

         MAP: begin
            p_r  <= map_r;
            p_i  <= map_i;
            iter <= '0;
            if (mode_q) begin
               cr <= julia_cr_q;
               ci <= julia_ci_q;
               zr <= map_r;
               zi <= map_i;
            end else begin
               cr <= map_r;
               ci <= map_i;
               zr <= '0;
               zi <= '0;
            end
         end

         ITER: begin
            // The cap check comes before the increment, so iter never wraps.
            if (!escape && !at_cap) begin
               zr   <= zr_next;
               zi   <= zi_next;
               iter <= iter + 1'b1;
            end
         end

         default: ;
      endcase
   end

endmodule

// File: tb/tb_fractal_engine.sv
// -----------------------------------------------------------------------------
// tb_fractal_engine
//
// Bench for fractal_engine. It runs directed cases and then random pixels.
// The expected result of every pixel comes from a plain-arithmetic model of
// the escape-time rules. Outputs are sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_fractal_engine;

   localparam int PW = 10;
   localparam int W  = 25;
   localparam int F  = 20;
   localparam int IW = 9;
   localparam int SB = 8;

   localparam longint ONE = 64'sd1 <<< F;

   logic                 clk;
   logic                 reset;
   logic                 in_valid;
   logic                 in_ready;
   logic [PW-1:0]        pixel_x;
   logic [PW-1:0]        pixel_y;
   logic [2:0]           zoom;
   logic signed [W-1:0]  x_offset;
   logic signed [W-1:0]  y_offset;
   logic                 mode;
   logic signed [W-1:0]  julia_cr;
   logic signed [W-1:0]  julia_ci;
   logic [IW-1:0]        iterations_max;
   logic                 out_valid;
   logic                 out_ready;
   logic [PW-1:0]        out_pixel_x;
   logic [PW-1:0]        out_pixel_y;
   logic signed [W-1:0]  out_cr;
   logic signed [W-1:0]  out_ci;
   logic [IW-1:0]        out_iterations;
   logic                 out_escaped;
   logic                 busy;

   int checks = 0;
   int errors = 0;

   fractal_engine #(
      .PIXEL_DATA_WIDTH  (PW),
      .ENGINE_DATA_WIDTH (W),
      .ENGINE_FRACT_WIDTH(F),
      .ITERATIONS_WIDTH  (IW),
      .STEP_BASE_SHIFT   (SB),
      .ESCAPE_INT        (4)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .pixel_x       (pixel_x),
      .pixel_y       (pixel_y),
      .zoom          (zoom),
      .x_offset      (x_offset),
      .y_offset      (y_offset),
      .mode          (mode),
      .julia_cr      (julia_cr),
      .julia_ci      (julia_ci),
      .iterations_max(iterations_max),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_pixel_x   (out_pixel_x),
      .out_pixel_y   (out_pixel_y),
      .out_cr        (out_cr),
      .out_ci        (out_ci),
      .out_iterations(out_iterations),
      .out_escaped   (out_escaped),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stops a run that hangs, reporting it as a failure.
   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "simulation did not finish");
   end

   task automatic check(input string tag, input longint observed, input longint expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Reference model: fixed-point arithmetic on plain 64-bit integers
   // ---------------------------------------------------------------------------
   function automatic longint wrap_w(input longint v);
      longint m;
      longint r;
      m = 64'sd1 <<< W;
      r = v & (m - 1);
      if (r >= m / 2) r = r - m;
      return r;
   endfunction

   function automatic longint sat_w(input longint v);
      longint hi;
      longint lo;
      hi = (64'sd1 <<< (W - 1)) - 1;
      lo = -(64'sd1 <<< (W - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

   // Product of two fixed-point values, rounded toward minus infinity.
   function automatic longint fx_mul(input longint a, input longint b);
      return sat_w((a * b) >>> F);
   endfunction

   function automatic longint map_axis(input longint off, input int pix, input int zm);
      return wrap_w(off + longint'(pix) * (64'sd1 <<< (F - SB - zm)));
   endfunction

   function automatic void ref_escape(input bit md, input longint pr, input longint pi,
                                      input longint jr, input longint ji, input int mx,
                                      output int n, output bit esc);
      longint c_r, c_i, z_r, z_i, a, b, ab;
      if (md) begin
         c_r = jr; c_i = ji; z_r = pr; z_i = pi;
      end else begin
         c_r = pr; c_i = pi; z_r = 0;  z_i = 0;
      end
      n   = 0;
      esc = 1'b0;
      while (1) begin
         a  = fx_mul(z_r, z_r);
         b  = fx_mul(z_i, z_i);
         ab = fx_mul(z_r, z_i);
         if (a + b > 4 * ONE) begin
            esc = 1'b1;
            break;
         end
         if (n == mx) break;
         z_r = wrap_w(a - b + c_r);
         z_i = wrap_w(2 * ab + c_i);
         n++;
      end
   endfunction

   // ---------------------------------------------------------------------------
   // One pixel transaction. out_ready is held low for `hold` cycles after
   // out_valid rises.
   // ---------------------------------------------------------------------------
   task automatic run_pixel(input string tag, input int px, input int py, input int zm,
                            input longint xo, input longint yo, input bit md,
                            input longint jr, input longint ji, input int mx, input int hold,
                            output int got_n, output bit got_esc,
                            output longint got_cr, output longint got_ci);
      longint exp_pr, exp_pi;
      int     exp_n;
      bit     exp_esc;
      int     wait_cyc;
      int     lat;
      int     bad;
      longint snap_cr, snap_ci;
      int     snap_n;

      exp_pr = map_axis(xo, px, zm);
      exp_pi = map_axis(yo, py, zm);
      ref_escape(md, exp_pr, exp_pi, jr, ji, mx, exp_n, exp_esc);

      @(negedge clk);
      pixel_x        = PW'(px);
      pixel_y        = PW'(py);
      zoom           = 3'(zm);
      x_offset       = W'(xo);
      y_offset       = W'(yo);
      mode           = md;
      julia_cr       = W'(jr);
      julia_ci       = W'(ji);
      iterations_max = IW'(mx);
      out_ready      = (hold == 0);
      in_valid       = 1'b1;

      wait_cyc = 0;
      while (!in_ready && wait_cyc < 50) begin
         @(negedge clk);
         wait_cyc++;
      end
      check({tag, "_accept"}, longint'(in_ready), 1);

      @(posedge clk);
      #1;
      // Scramble the request inputs once the pixel has been accepted.
      in_valid       = 1'b0;
      pixel_x        = PW'($urandom);
      pixel_y        = PW'($urandom);
      zoom           = 3'($urandom);
      x_offset       = W'($urandom);
      y_offset       = W'($urandom);
      mode           = 1'($urandom);
      julia_cr       = W'($urandom);
      julia_ci       = W'($urandom);
      iterations_max = IW'($urandom);
      check({tag, "_busy_in_ready"}, longint'({busy, in_ready}), 2);

      lat = 0;
      while (!out_valid && lat < mx + 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "_latency"}, lat, exp_n + 2);
      check({tag, "_px"}, longint'(out_pixel_x), px);
      check({tag, "_py"}, longint'(out_pixel_y), py);
      check({tag, "_cr"}, longint'(out_cr), exp_pr);
      check({tag, "_ci"}, longint'(out_ci), exp_pi);
      check({tag, "_iter"}, longint'(out_iterations), exp_n);
      check({tag, "_escaped"}, longint'(out_escaped), longint'(exp_esc));

      got_n   = int'(out_iterations);
      got_esc = out_escaped;
      got_cr  = longint'(out_cr);
      got_ci  = longint'(out_ci);

      if (hold > 0) begin
         snap_cr = longint'(out_cr);
         snap_ci = longint'(out_ci);
         snap_n  = int'(out_iterations);
         bad     = 0;
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || longint'(out_cr) != snap_cr ||
                longint'(out_ci) != snap_ci || int'(out_iterations) != snap_n)
               bad++;
         end
         check({tag, "_bp_stable"}, bad, 0);
         out_ready = 1'b1;
      end

      @(posedge clk);
      #1;
      check({tag, "_back_idle"}, longint'({in_ready, out_valid, busy}), 4);
   endtask

   // ---------------------------------------------------------------------------
   // Directed and random sequence
   // ---------------------------------------------------------------------------
   initial begin
      int     n;
      bit     esc;
      longint gcr, gci;
      longint xo, yo, jr, ji;

      reset          = 1'b1;
      in_valid       = 1'b0;
      out_ready      = 1'b1;
      pixel_x        = '0;
      pixel_y        = '0;
      zoom           = '0;
      x_offset       = '0;
      y_offset       = '0;
      mode           = 1'b0;
      julia_cr       = '0;
      julia_ci       = '0;
      iterations_max = '0;

      repeat (3) @(posedge clk);
      #1;
      check("reset_ctrl", longint'({in_ready, out_valid, busy}), 4);
      check("reset_data", longint'({out_pixel_x, out_pixel_y, out_cr, out_ci,
                                    out_iterations, out_escaped}), 0);
      @(negedge clk);
      reset = 1'b0;

      // Mapping of pixel 320 with zero iterations allowed.
      run_pixel("map", 320, 0, 0, -64'sd2097152, 0, 1'b0, 0, 0, 0, 0, n, esc, gcr, gci);
      check("map_cr_const", gcr, -786432);
      check("map_ci_const", gci, 0);
      check("map_n_const", n, 0);
      check("map_esc_const", longint'(esc), 0);

      // c = 2.0 escapes on iteration 2.
      run_pixel("escape", 0, 0, 0, 64'sd2097152, 0, 1'b0, 0, 0, 100, 0, n, esc, gcr, gci);
      check("escape_n_const", n, 2);
      check("escape_esc_const", longint'(esc), 1);

      // c = -2.0 keeps |z|^2 at exactly 4.0, which does not count as escaping.
      run_pixel("edge_m2", 0, 0, 0, -64'sd2097152, 0, 1'b0, 0, 0, 50, 0, n, esc, gcr, gci);
      check("edge_m2_n_const", n, 50);
      check("edge_m2_esc_const", longint'(esc), 0);

      // c = 0 never escapes.
      run_pixel("zero_c", 0, 0, 0, 0, 0, 1'b0, 0, 0, 37, 0, n, esc, gcr, gci);
      check("zero_c_n_const", n, 37);

      // Julia set with c = 0.
      run_pixel("julia_15", 0, 0, 0, 64'sd1572864, 0, 1'b1, 0, 0, 30, 0, n, esc, gcr, gci);
      check("julia_15_n_const", n, 1);
      check("julia_15_esc_const", longint'(esc), 1);
      run_pixel("julia_05", 0, 0, 0, 64'sd524288, 0, 1'b1, 0, 0, 20, 0, n, esc, gcr, gci);
      check("julia_05_n_const", n, 20);
      check("julia_05_esc_const", longint'(esc), 0);

      // Output held back by the consumer for 10 cycles.
      run_pixel("bp", 100, 50, 2, -ONE, ONE / 4, 1'b0, 0, 0, 15, 10, n, esc, gcr, gci);

      // Reset while iterating: the pixel is dropped and no result appears.
      @(negedge clk);
      pixel_x        = '0;
      pixel_y        = '0;
      zoom           = '0;
      x_offset       = '0;
      y_offset       = '0;
      mode           = 1'b0;
      iterations_max = IW'(400);
      in_valid       = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      check("mid_busy", longint'(busy), 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      check("mid_reset_ctrl", longint'({in_ready, out_valid, busy}), 4);
      repeat (5) @(posedge clk);
      #1;
      check("mid_reset_quiet", longint'({in_ready, out_valid}), 2);
      run_pixel("after_reset", 7, 9, 3, -ONE / 2, ONE / 8, 1'b0, 0, 0, 25, 0,
                n, esc, gcr, gci);

      // Random pixels, issued back to back, with occasional backpressure.
      for (int t = 0; t < 20; t++) begin
         xo = longint'($urandom_range(0, 3670016)) - 64'sd2621440;
         yo = longint'($urandom_range(0, 3145728)) - 64'sd1572864;
         jr = longint'($urandom_range(0, 2097152)) - 64'sd1048576;
         ji = longint'($urandom_range(0, 2097152)) - 64'sd1048576;
         run_pixel($sformatf("rnd%0d", t), int'($urandom_range(0, 1023)),
                   int'($urandom_range(0, 1023)), int'($urandom_range(0, 7)),
                   xo, yo, 1'($urandom), jr, ji, int'($urandom_range(0, 40)),
                   (t % 5 == 4) ? 3 : 0, n, esc, gcr, gci);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
